// File: rtl/quat_uart_pkg.sv
// Shared definitions for the quaternion UART link: framing constants, FSM states
// and the payload checksum used by both the transmitter and the matching receiver.
package quat_uart_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // XOR of the eight payload bytes; the sync byte never contributes.
    function automatic logic [7:0] frame_checksum(input logic [63:0] payload);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ payload[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load starts a new period, tick is high in the last
// cycle of that period. Shared by the transmitter and the receiver.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int               CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Count down from the reload value; tick is registered so it lands on cnt_r == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= ZERO;
            tick_r <= 1'b0;
        end else if (load) begin
            cnt_r  <= RELOAD;
            tick_r <= 1'b0;
        end else if (cnt_r != ZERO) begin
            cnt_r  <= cnt_r - ONE;
            tick_r <= (cnt_r == ONE);
        end else begin
            cnt_r  <= cnt_r;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/quat_frame_tx.sv
// Framed 8N1 transmitter: latches q0..q3 on send and emits SYNC, eight payload
// bytes (little-endian per component) and an XOR checksum, gap-free.
module quat_frame_tx #(
    parameter int         CLK_FREQ  = 50000000,
    parameter int         BAUD      = 9600,
    parameter logic [7:0] SYNC_BYTE = quat_uart_pkg::SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               send,
    input  logic signed [15:0] q0,
    input  logic signed [15:0] q1,
    input  logic signed [15:0] q2,
    input  logic signed [15:0] q3,
    output logic               tx,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    import quat_uart_pkg::*;

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [3:0] LAST_BYTE    = 4'(FRAME_BYTES - 1);

    uart_state_e state_r;
    logic [63:0] shadow_r;
    logic [7:0]  chk_r;
    logic [7:0]  shift_r;
    logic [3:0]  byte_idx_r;
    logic [2:0]  bit_idx_r;
    logic        tx_r;
    logic        busy_r;
    logic        done_r;
    logic        overrun_r;

    logic        tick_s;
    logic        load_s;
    logic [7:0]  cur_byte_s;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .tick (tick_s)
    );

    // Restart the bit period on frame acceptance and at every bit boundary.
    always_comb begin
        load_s = 1'b0;
        case (state_r)
            IDLE:              load_s = send;
            START, DATA, STOP: load_s = tick_s;
            default:           load_s = 1'b0;
        endcase
    end

    // Byte currently being framed, selected from the latched shadow.
    always_comb begin
        cur_byte_s = SYNC_BYTE;
        case (byte_idx_r)
            4'd0:    cur_byte_s = SYNC_BYTE;
            4'd1:    cur_byte_s = shadow_r[7:0];
            4'd2:    cur_byte_s = shadow_r[15:8];
            4'd3:    cur_byte_s = shadow_r[23:16];
            4'd4:    cur_byte_s = shadow_r[31:24];
            4'd5:    cur_byte_s = shadow_r[39:32];
            4'd6:    cur_byte_s = shadow_r[47:40];
            4'd7:    cur_byte_s = shadow_r[55:48];
            4'd8:    cur_byte_s = shadow_r[63:56];
            4'd9:    cur_byte_s = chk_r;
            default: cur_byte_s = SYNC_BYTE;
        endcase
    end

    // Frame sequencer; tx, busy, done and overrun are all driven from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            shadow_r   <= 64'h0;
            chk_r      <= 8'h00;
            shift_r    <= 8'h00;
            byte_idx_r <= 4'd0;
            bit_idx_r  <= 3'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            overrun_r <= send & busy_r;
            case (state_r)
                IDLE: begin
                    if (send) begin
                        shadow_r   <= {q3, q2, q1, q0};
                        chk_r      <= frame_checksum({q3, q2, q1, q0});
                        byte_idx_r <= 4'd0;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= START;
                    end else begin
                        tx_r       <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        tx_r      <= cur_byte_s[0];
                        shift_r   <= {1'b0, cur_byte_s[7:1]};
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                    end else begin
                        state_r   <= START;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (byte_idx_r < LAST_BYTE) begin
                            byte_idx_r <= byte_idx_r + 4'd1;
                            tx_r       <= 1'b0;
                            state_r    <= START;
                        end else begin
                            byte_idx_r <= 4'd0;
                            tx_r       <= 1'b1;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= IDLE;
                        end
                    end else begin
                        state_r <= STOP;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_quat_frame_tx.sv
// Bench for quat_frame_tx: table of frames, a line decoder feeding a byte
// scoreboard, and inline sequences for overrun, chained send and mid-frame reset.
module tb_quat_frame_tx;

    localparam int CPB = 16;
    localparam int FRAME_CYC = 100 * CPB;

    logic               clk;
    logic               rst;
    logic               send;
    logic signed [15:0] q0, q1, q2, q3;
    logic               tx, busy, done, overrun;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    quat_frame_tx #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .send   (send),
        .q0     (q0),
        .q1     (q1),
        .q2     (q2),
        .q3     (q3),
        .tx     (tx),
        .busy   (busy),
        .done   (done),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q0, q1, q2, q3;
        logic [7:0]  chk;
        int          ovr_at;
        int          rst_at;
        bit          chained;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_frame(input int i);
        exp_q.push_back(8'hA5);
        exp_q.push_back(tbl[i].q0[7:0]);
        exp_q.push_back(tbl[i].q0[15:8]);
        exp_q.push_back(tbl[i].q1[7:0]);
        exp_q.push_back(tbl[i].q1[15:8]);
        exp_q.push_back(tbl[i].q2[7:0]);
        exp_q.push_back(tbl[i].q2[15:8]);
        exp_q.push_back(tbl[i].q3[7:0]);
        exp_q.push_back(tbl[i].q3[15:8]);
        exp_q.push_back(tbl[i].chk);
    endtask

    task automatic drive_q(input int i);
        q0 = tbl[i].q0;
        q1 = tbl[i].q1;
        q2 = tbl[i].q2;
        q3 = tbl[i].q3;
    endtask

    // Line decoder: records 160 samples per byte and checks width, stop bit and value.
    initial begin
        logic [159:0] samp;
        int           mcnt;
        bit           mact;
        logic [7:0]   got;
        bit           ok;
        mact = 1'b0;
        mcnt = 0;
        samp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mact = 1'b0;
            end else if (!mact) begin
                if (tx == 1'b0) begin
                    mact = 1'b1;
                    samp[0] = tx;
                    mcnt = 1;
                end
            end else begin
                samp[mcnt] = tx;
                mcnt++;
                if (mcnt == 160) begin
                    mact = 1'b0;
                    ok = 1'b1;
                    for (int b = 0; b < 10; b++)
                        for (int k = 1; k < CPB; k++)
                            if (samp[b*CPB + k] !== samp[b*CPB]) ok = 1'b0;
                    if (samp[9*CPB] !== 1'b1) ok = 1'b0;
                    for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*CPB];
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h with no byte expected", got);
                    end else begin
                        chk("line_byte", {24'h0, got}, {24'h0, exp_q.pop_front()});
                        chk("bit_framing", {31'h0, ok}, 32'h1);
                    end
                end
            end
        end
    end

    initial begin
        int  bcnt, ovr_cnt, idle_bad, done_bad;
        bit  fin, pre;
        tbl[0] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 8'h01, 0,   0,   1'b0};
        tbl[1] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 8'h40, 500, 0,   1'b0};
        tbl[2] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 8'h80, 0,   0,   1'b1};
        tbl[3] = '{16'hDEAD, 16'hBEEF, 16'h0102, 16'h7F80, 8'hDE, 0,   700, 1'b0};
        tbl[4] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 8'h40, 0,   0,   1'b0};
        tbl[5] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h00FF, 8'h7E, 0,   0,   1'b1};

        rst = 1'b1; send = 1'b0; q0 = 16'h0; q1 = 16'h0; q2 = 16'h0; q3 = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", {31'h0, tx}, 32'h1);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_overrun", {31'h0, overrun}, 32'h0);
        idle_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        chk("idle_line", idle_bad, 0);

        pre = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!pre) begin
                push_frame(i);
                @(posedge clk);
                #1 drive_q(i); send = 1'b1;
                @(posedge clk);
                #1 send = 1'b0;
                bcnt = 0;
            end else begin
                bcnt = 1;
            end
            pre = 1'b0;
            ovr_cnt = 0;
            fin = 1'b0;
            for (int c = 0; c < FRAME_CYC + 100 && !fin; c++) begin
                @(negedge clk);
                if (busy === 1'b1) bcnt++;
                if (overrun === 1'b1) ovr_cnt++;
                if (tbl[i].ovr_at > 0 && bcnt == tbl[i].ovr_at + 1 && send) begin
                    send = 1'b0;
                    chk("overrun_pulse", {31'h0, overrun}, 32'h1);
                end
                if (tbl[i].ovr_at > 0 && bcnt == tbl[i].ovr_at && !send) begin
                    send = 1'b1;
                    q0 = 16'h5555; q1 = 16'h6666; q2 = 16'h7777; q3 = 16'h1111;
                end
                if (tbl[i].rst_at > 0 && bcnt == tbl[i].rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("rst_abort", {29'h0, tx, busy, done}, {29'h0, 3'b100});
                    @(negedge clk);
                    rst = 1'b0;
                    done_bad = 0;
                    repeat (20) begin
                        @(negedge clk);
                        if (done !== 1'b0 || tx !== 1'b1) done_bad++;
                    end
                    chk("rst_no_done", done_bad, 0);
                    exp_q.delete();
                    fin = 1'b1;
                end else if (done === 1'b1) begin
                    fin = 1'b1;
                    chk("busy_cycles", bcnt, FRAME_CYC);
                    chk("done_busy_low", {31'h0, busy}, 32'h0);
                    chk("overrun_count", ovr_cnt, (tbl[i].ovr_at > 0) ? 1 : 0);
                    chk("frame_bytes_left", exp_q.size(), 0);
                    if (i + 1 < 6 && tbl[i+1].chained) begin
                        push_frame(i + 1);
                        drive_q(i + 1);
                        send = 1'b1;
                        @(posedge clk);
                        #1 send = 1'b0;
                        @(negedge clk);
                        chk("chain_no_gap", {30'h0, tx, busy}, {30'h0, 2'b01});
                        pre = 1'b1;
                    end else begin
                        @(negedge clk);
                        chk("post_frame_idle", {29'h0, tx, busy, done}, {29'h0, 3'b100});
                    end
                end
            end
            if (!fin) chk("frame_timeout", 32'h0, 32'h1);
        end

        repeat (200) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
